// File: rtl/cache_refill_ctrl.sv
// Line-refill engine: fetches a 4-word block from 32-bit memory on a miss
// and delivers the assembled line with a one-cycle valid pulse.
module cache_refill_ctrl #(
  parameter int WORD_SIZE  = 32,
  parameter int WORD_COUNT = 4,
  parameter int ADDR_W     = 15,
  parameter int TIMEOUT    = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            missReq,
  input  logic [ADDR_W-1:0]               missAddr,
  output logic                            memReq,
  output logic [ADDR_W-1:0]               memAddr,
  input  logic                            memAck,
  input  logic                            memRvalid,
  input  logic [WORD_SIZE-1:0]            memRdata,
  output logic [WORD_SIZE*WORD_COUNT-1:0] lineData,
  output logic                            lineValid,
  output logic                            busy,
  output logic                            timeoutErr,
  output logic [13:0]                     missCount
);

  localparam int BEAT_W = $clog2(WORD_COUNT);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMO_V  = TMR_W'(TIMEOUT);
  localparam logic [BEAT_W-1:0] LAST   = BEAT_W'(WORD_COUNT - 1);
  localparam logic [ADDR_W-1:0] OFFMSK = ADDR_W'(WORD_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  base;
  logic [BEAT_W-1:0]  beat;
  logic [TMR_W-1:0]   timer;

  logic accept;
  logic acked;
  logic capture;
  logic tmo;
  logic in_beat;

  assign in_beat = (state == S_REQ) || (state == S_WAIT);
  assign tmo     = in_beat && (timer == TMO_V);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    acked   = 1'b0;
    capture = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (missReq) begin
          accept  = 1'b1;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (tmo) begin
          state_n = S_IDLE;
        end else if (memAck) begin
          acked   = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tmo) begin
          state_n = S_IDLE;
        end else if (memRvalid) begin
          capture = 1'b1;
          state_n = (beat == LAST) ? S_DONE : S_REQ;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      base       <= '0;
      beat       <= '0;
      timer      <= '0;
      lineData   <= '0;
      timeoutErr <= 1'b0;
      missCount  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        base       <= missAddr & ~OFFMSK;
        beat       <= '0;
        timeoutErr <= 1'b0;
        if (missCount != 14'h3FFF) missCount <= missCount + 14'd1;
      end
      // Timer restarts at every beat start and again once memory accepts
      if (accept || acked || capture) timer <= '0;
      else if (in_beat)               timer <= timer + 1'b1;
      if (capture && beat != LAST) beat <= beat + 1'b1;
      if (tmo) timeoutErr <= 1'b1;
      for (int i = 0; i < WORD_COUNT; i++) begin
        if (capture && beat == BEAT_W'(i))
          lineData[i*WORD_SIZE +: WORD_SIZE] <= memRdata;
      end
    end
  end

  assign memReq    = (state == S_REQ);
  assign memAddr   = base + {{(ADDR_W-BEAT_W){1'b0}}, beat};
  assign lineValid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: cycle table for the fast refill,
// hand sequences for slow memory, timeout, reset, stray pulses, saturation.
module tb_cache_refill_ctrl;

  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         missReq = 1'b0;
  logic [14:0]  missAddr = '0;
  logic         memReq;
  logic [14:0]  memAddr;
  logic         memAck = 1'b0;
  logic         memRvalid = 1'b0;
  logic [31:0]  memRdata = '0;
  logic [127:0] lineData;
  logic         lineValid;
  logic         busy;
  logic         timeoutErr;
  logic [13:0]  missCount;

  logic         missReq2 = 1'b0;
  logic [14:0]  missAddr2 = 15'h0040;
  logic         memReq2;
  logic [14:0]  memAddr2;
  logic         memAck2 = 1'b0;
  logic         memRvalid2 = 1'b0;
  logic [31:0]  memRdata2 = '0;
  logic [127:0] lineData2;
  logic         lineValid2;
  logic         busy2;
  logic         timeoutErr2;
  logic [13:0]  missCount2;

  always #5 clk = ~clk;

  cache_refill_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .missReq(missReq), .missAddr(missAddr),
    .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
    .memRvalid(memRvalid), .memRdata(memRdata), .lineData(lineData),
    .lineValid(lineValid), .busy(busy), .timeoutErr(timeoutErr),
    .missCount(missCount)
  );

  // Short timeout lets the saturation run abort each refill quickly
  cache_refill_ctrl #(.TIMEOUT(2)) dut2 (
    .clk(clk), .rst(rst), .missReq(missReq2), .missAddr(missAddr2),
    .memReq(memReq2), .memAddr(memAddr2), .memAck(memAck2),
    .memRvalid(memRvalid2), .memRdata(memRdata2), .lineData(lineData2),
    .lineValid(lineValid2), .busy(busy2), .timeoutErr(timeoutErr2),
    .missCount(missCount2)
  );

  int tests = 0;
  int fails = 0;
  int lv_cnt = 0;

  always @(negedge clk) if (lineValid) lv_cnt++;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic [14:0] addr;
    logic        ack;
    logic        rv;
    logic [31:0] data;
    logic        ereq;
    logic [14:0] eaddr;
    logic        ebusy;
    logic        elv;
  } vec_t;

  vec_t tv[11];

  task automatic start_refill(input logic [14:0] a);
    missReq  = 1'b1;
    missAddr = a;
    @(negedge clk);
    missReq  = 1'b0;
  endtask

  task automatic serve_beat(input logic [14:0] ea, input int ackd,
                            input int rvd, input logic [31:0] d,
                            input bit give_rv);
    int n;
    n = 0;
    while (!memReq && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("beat_addr", memReq ? {113'h0, memAddr} : 128'hx, {113'h0, ea});
    repeat (ackd) @(negedge clk);
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    if (give_rv) begin
      repeat (rvd - 1) @(negedge clk);
      memRvalid = 1'b1;
      memRdata  = d;
      @(negedge clk);
      memRvalid = 1'b0;
    end
  endtask

  task automatic full_refill(input logic [14:0] a, input logic [14:0] base,
                             input logic [127:0] line, input int ackd,
                             input int rvd);
    start_refill(a);
    for (int b = 0; b < 4; b++)
      serve_beat(base + 15'(b), ackd, rvd, line[32*b +: 32], 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] l1, l2, l3, l4;
    int lv0, k;
    bit stuck;
    l1 = {32'hD3D3_3333, 32'hC2C2_2222, 32'hB1B1_1111, 32'hA0A0_0000};
    l2 = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    l3 = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    l4 = {32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0};

    //         req addr     ack  rv   data          ereq eaddr    ebusy elv
    tv[0]  = '{1, 15'h1235, 0, 0, 32'h0,          0, 15'h0,    0, 0};
    tv[1]  = '{0, 15'h0,    1, 0, 32'h0,          1, 15'h1234, 1, 0};
    tv[2]  = '{0, 15'h0,    0, 1, l1[31:0],       0, 15'h0,    1, 0};
    tv[3]  = '{0, 15'h0,    1, 0, 32'h0,          1, 15'h1235, 1, 0};
    tv[4]  = '{0, 15'h0,    0, 1, l1[63:32],      0, 15'h0,    1, 0};
    tv[5]  = '{0, 15'h0,    1, 0, 32'h0,          1, 15'h1236, 1, 0};
    tv[6]  = '{0, 15'h0,    0, 1, l1[95:64],      0, 15'h0,    1, 0};
    tv[7]  = '{0, 15'h0,    1, 0, 32'h0,          1, 15'h1237, 1, 0};
    tv[8]  = '{0, 15'h0,    0, 1, l1[127:96],     0, 15'h0,    1, 0};
    tv[9]  = '{0, 15'h0,    0, 0, 32'h0,          0, 15'h0,    1, 1};
    tv[10] = '{0, 15'h0,    0, 0, 32'h0,          0, 15'h0,    0, 0};

    // Reset state
    #1;
    check("rst_outs", {memReq, busy, lineValid, timeoutErr}, 4'b0);
    check("rst_addr", memAddr, 0);
    check("rst_line", lineData, 0);
    check("rst_cnt", missCount, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 1: immediate memory, cycle by cycle
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {memReq, busy, lineValid, memReq ? memAddr : 15'h0},
            {tv[i].ereq, tv[i].ebusy, tv[i].elv, tv[i].eaddr});
      missReq   = tv[i].req;
      missAddr  = tv[i].addr;
      memAck    = tv[i].ack;
      memRvalid = tv[i].rv;
      memRdata  = tv[i].data;
    end
    check("t1_line", lineData, l1);
    check("t1_cnt", missCount, 1);
    check("t1_lvcnt", lv_cnt, 1);

    // 2: top-of-memory line, slow memory
    lv0 = lv_cnt;
    full_refill(15'h7FFE, 15'h7FFC, l2, 3, 5);
    check("t2_lv_pulse", lineValid, 1);
    @(negedge clk);
    check("t2_lv_one", {lineValid, busy}, 2'b00);
    check("t2_line", lineData, l2);
    check("t2_lvcnt", lv_cnt - lv0, 1);
    check("t2_cnt", missCount, 2);

    // 3: no rvalid on beat 2 -> timeout
    lv0 = lv_cnt;
    start_refill(15'h0101);
    serve_beat(15'h0100, 0, 1, 32'h1, 1'b1);
    serve_beat(15'h0101, 0, 1, 32'h2, 1'b1);
    serve_beat(15'h0102, 0, 1, 32'h3, 1'b0);
    k = 1;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t3_tmo_cycles", k, TMO + 2);
    check("t3_err", {timeoutErr, busy}, 2'b10);
    check("t3_no_lv", lv_cnt - lv0, 0);
    start_refill(15'h0200);
    check("t3_err_clr", timeoutErr, 0);
    for (int b = 0; b < 4; b++)
      serve_beat(15'h0200 + 15'(b), 0, 1, l3[32*b +: 32], 1'b1);
    check("t3_lv", lineValid, 1);
    @(negedge clk);
    check("t3_line", lineData, l3);
    check("t3_cnt", missCount, 4);

    // 4: async reset in the middle of beat 1
    lv0 = lv_cnt;
    start_refill(15'h0300);
    serve_beat(15'h0300, 0, 1, 32'h77, 1'b1);
    serve_beat(15'h0301, 0, 1, 32'h0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("t4_outs", {memReq, busy, lineValid, timeoutErr}, 4'b0);
    check("t4_addr", memAddr, 0);
    check("t4_line", lineData, 0);
    check("t4_cnt", missCount, 0);
    @(negedge clk);
    rst = 1'b1;
    check("t4_no_lv", lv_cnt - lv0, 0);
    full_refill(15'h0404, 15'h0404, l4, 1, 2);
    check("t4_lv", lineValid, 1);
    @(negedge clk);
    check("t4_line2", lineData, l4);
    check("t4_cnt2", missCount, 1);

    // 5: stray ack/rvalid while idle
    lv0 = lv_cnt;
    for (int i = 0; i < 3; i++) begin
      memAck    = 1'b1;
      memRvalid = 1'b1;
      memRdata  = 32'hFFFF_0000 + 32'(i);
      @(negedge clk);
      check($sformatf("t5_idle%0d", i), {busy, memReq}, 2'b00);
    end
    memAck    = 1'b0;
    memRvalid = 1'b0;
    @(negedge clk);
    check("t5_line", lineData, l4);
    check("t5_lv", lv_cnt - lv0, 0);
    check("t5_cnt", missCount, 1);

    // 6: saturate the miss counter on the short-timeout instance
    stuck = 1'b0;
    for (int i = 0; i < 16384 && !stuck; i++) begin
      missReq2 = 1'b1;
      @(negedge clk);
      missReq2 = 1'b0;
      k = 0;
      while (busy2 && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (busy2) stuck = 1'b1;
      if (i == 16382) check("t6_cnt_max", missCount2, 14'h3FFF);
    end
    check("t6_not_stuck", stuck, 0);
    check("t6_cnt_sat", missCount2, 14'h3FFF);
    check("t6_err", timeoutErr2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
